// File: rtl/alu_mul_ctrl.sv
// Sequencing controller that drives an external alu as an n-bit signed
// shift-and-add multiplier, one multiplier bit per cycle, with valid/ready on both sides.
module alu_mul_ctrl #(
    parameter int n = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     in_a,
    input  logic [n-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*n-1:0]   out_p,
    output logic             busy,
    output logic             alu_in_a_lsb,
    output logic             alu_op,
    output logic [n-1:0]     alu_in_b,
    input  logic [n-1:0]     alu_out
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [n-1:0]    hi_q, hi_d;
    logic [n-1:0]    lo_q, lo_d;
    logic [n-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            run;
    logic            last_step;
    logic            sub_step;
    logic            addend_msb;
    logic [n:0]      sum;

    assign run          = (state_q == S_RUN);
    assign last_step    = (cnt_q == CW'(n - 1));
    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign alu_in_a_lsb = run & lo_q[0];
    assign alu_op       = run & last_step;
    assign alu_in_b     = b_q;
    assign out_p        = {hi_q, lo_q};

    // The alu returns -B only mod 2^n, so -(-2^(n-1)) wraps to itself. The true
    // sign of -B is negative exactly when B is strictly positive; use that as the
    // extension bit on the subtract step so the most-negative square stays exact.
    assign sub_step   = alu_op & alu_in_a_lsb;
    assign addend_msb = sub_step ? (~b_q[n-1] & (|b_q)) : alu_out[n-1];
    assign sum        = {hi_q[n-1], hi_q} + {addend_msb, alu_out};

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    b_d     = in_b;
                    hi_d    = '0;
                    lo_d    = in_a;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                hi_d  = sum[n:1];
                lo_d  = {sum[0], lo_q[n-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Self-checking bench for alu_mul_ctrl: behavioural alu, product scoreboard,
// directed vector table plus backpressure, abort-by-reset and operand-change sequences.
module tb_alu_mul_ctrl;

    localparam int N = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;
    logic             busy;
    logic             alu_in_a_lsb;
    logic             alu_op;
    logic [N-1:0]     alu_in_b;
    logic [N-1:0]     alu_out;

    always #5 clk = ~clk;

    alu_mul_ctrl #(.n(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_p        (out_p),
        .busy         (busy),
        .alu_in_a_lsb (alu_in_a_lsb),
        .alu_op       (alu_op),
        .alu_in_b     (alu_in_b),
        .alu_out      (alu_out)
    );

    // Behavioural alu: add or subtract the multiplicand, modulo 2^N.
    assign alu_out = alu_in_a_lsb ? (alu_op ? (N'(0) - alu_in_b) : alu_in_b) : '0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    logic [2*N-1:0]   sb_q[$];
    vec_t             vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        return (2*N)'(sa * sbv);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_p"},     out_p, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_alu_lsb"},   alu_in_a_lsb, 0);
        check({tag, "_alu_op"},    alu_op, 0);
        check({tag, "_alu_in_b"},  alu_in_b, 0);
    endtask

    // Called at a falling edge; returns at the falling edge just after acceptance.
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
        int guard = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        sb_q.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts cycles from acceptance to out_valid; ops marks RUN cycles with alu_op high.
    task automatic wait_result(output int lat, output logic [31:0] ops);
        lat = 0;
        ops = '0;
        while (!out_valid && lat < 40) begin
            if (alu_op && lat < 31) ops[lat+1] = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result(input string name);
        logic [2*N-1:0] exp;
        check({name, "_valid"}, out_valid, 1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check(name, out_p, exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: product 0x%0h with empty scoreboard", name, out_p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int          lat;
        logic [31:0] ops;

        vecs[0] = '{a: 12'h003, b: 12'h005, p: 24'h00000F};
        vecs[1] = '{a: 12'hFFF, b: 12'h001, p: 24'hFFFFFF};
        vecs[2] = '{a: 12'h800, b: 12'h800, p: 24'h400000};
        vecs[3] = '{a: 12'h7FF, b: 12'h800, p: 24'hC00800};
        vecs[4] = '{a: 12'h7FF, b: 12'h7FF, p: 24'h3FF001};
        vecs[5] = '{a: 12'h000, b: 12'hABC, p: 24'h000000};
        vecs[6] = '{a: 12'h800, b: 12'h001, p: 24'hFFF800};
        vecs[7] = '{a: 12'hFFF, b: 12'hFFF, p: 24'h000001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed table with out_ready tied high.
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b);
            sb_q[sb_q.size()-1] = vecs[i].p;
            wait_result(lat, ops);
            check("latency", lat, N);
            check("alu_op_cycle", ops, 64'(1) << N);
            take_result($sformatf("vec%0d", i));
        end

        // Operands changing after acceptance must not affect the result.
        accept(12'h123, 12'h9AB);
        in_a = 12'hEDC;
        in_b = 12'h654;
        wait_result(lat, ops);
        in_a = 12'h0F0;
        check("chg_latency", lat, N);
        take_result("operand_change");

        // Backpressure: result held 5 cycles while a second request waits.
        out_ready = 1'b0;
        accept(12'h456, 12'h789);
        wait_result(lat, ops);
        check("bp_latency", lat, N);
        in_a     = 12'h111;
        in_b     = 12'h222;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_stable", out_p, model(12'h456, 12'h789));
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(negedge clk);
        end
        take_result("bp_first");
        @(posedge clk);
        sb_q.push_back(model(12'h111, 12'h222));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", busy, 1);
        wait_result(lat, ops);
        check("bp_second_latency", lat, N);
        take_result("bp_second");

        // Asynchronous reset in RUN cycle 6 aborts the operation.
        accept(12'h5A5, 12'h3C3);
        repeat (5) @(negedge clk);
        check("abort_busy", busy, 1);
        check("abort_alu_in_b", alu_in_b, 12'h3C3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        accept(12'h003, 12'h005);
        wait_result(lat, ops);
        check("post_abort_latency", lat, N);
        check("post_abort_p", out_p, 24'h00000F);
        take_result("post_abort");

        // Random signed pairs against the reference model.
        for (int i = 0; i < 1000; i++) begin
            accept(N'($urandom), N'($urandom));
            wait_result(lat, ops);
            take_result("rand");
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
